// File: rtl/usb_tx_pkg.sv
// Shared USB transmit-path definitions.
// Holds the bit-stuffing run length default and the stuffer state encoding,
// which the NRZI/EOP stages also import for debug visibility.
package usb_tx_pkg;

    // Consecutive 1s that force a stuff bit.
    localparam int unsigned RUN_LEN_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STUFF  = 2'd2
    } stuff_state_t;

endpackage

// File: rtl/run_counter.sv
// Saturating counter of consecutive 1s in the bit stream.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - advance the counter this cycle
//   bit_in    - bit being consumed (1 extends the run, 0 breaks it)
//   clr       - force the count to zero (takes priority over bit_in when en)
//   cnt       - current run length, saturates at RUN_LEN
//   hit       - bit_in would complete a run of RUN_LEN 1s
module run_counter
    import usb_tx_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         bit_in,
    input  logic                         clr,
    output logic [$clog2(RUN_LEN+1)-1:0] cnt,
    output logic                         hit
);

    localparam int unsigned CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] HitVal = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] MaxVal = CW'(RUN_LEN);

    logic [CW-1:0] cnt_q, cnt_d;

    assign hit = (cnt_q == HitVal) & bit_in;
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr || !bit_in) begin
                cnt_d = '0;
            end else if (cnt_q != MaxVal) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_stuffer.sv
// USB transmit bit-stuffing stage: inserts a 0 after every RUN_LEN consecutive
// 1s, with a single output register stage and per-packet stuff-bit count.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_bit/in_last, in_ready   - upstream serial bit stream
//   out_valid/out_bit/out_last, out_ready - stuffed stream to the NRZI encoder
//   pkt_stuffed           - stuff bits inserted in the current/most recent packet
module bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_stuffed
);

    localparam int unsigned CW = $clog2(RUN_LEN + 1);

    stuff_state_t     state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             out_last_q, out_last_d;
    logic             pend_last_q, pend_last_d;
    logic [CNT_W-1:0] pkt_stuffed_q, pkt_stuffed_d;

    logic          slot_free;
    logic          stuff_pending;
    logic          accept;
    logic          run_hit;
    logic [CW-1:0] ones_cnt;

    assign slot_free     = ~out_valid_q | out_ready;
    assign stuff_pending = (state_q == STUFF);
    assign in_ready      = slot_free & ~stuff_pending & ~rst;
    assign accept        = in_valid & in_ready;

    // The stuff bit clears the run; a non-stuffing last bit also ends it.
    run_counter #(
        .RUN_LEN (RUN_LEN)
    ) u_run_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (slot_free & (stuff_pending | accept)),
        .bit_in (in_bit),
        .clr    (stuff_pending | (in_last & ~run_hit)),
        .cnt    (ones_cnt),
        .hit    (run_hit)
    );

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_bit_d     = out_bit_q;
        out_last_d    = out_last_q;
        pend_last_d   = pend_last_q;
        pkt_stuffed_d = pkt_stuffed_q;

        if (slot_free) begin
            if (stuff_pending) begin
                out_valid_d = 1'b1;
                out_bit_d   = 1'b0;
                out_last_d  = pend_last_q;
                if (pkt_stuffed_q != '1) begin
                    pkt_stuffed_d = pkt_stuffed_q + 1'b1;
                end
                state_d = pend_last_q ? IDLE : ACTIVE;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_bit_d   = in_bit;
                // First bit of a new packet restarts the count.
                if (state_q == IDLE) begin
                    pkt_stuffed_d = '0;
                end
                if (run_hit) begin
                    // Hold back the packet end until the stuff 0 goes out.
                    pend_last_d = in_last;
                    out_last_d  = 1'b0;
                    state_d     = STUFF;
                end else begin
                    out_last_d = in_last;
                    state_d    = in_last ? IDLE : ACTIVE;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
            out_last_q    <= 1'b0;
            pend_last_q   <= 1'b0;
            pkt_stuffed_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_bit_q     <= out_bit_d;
            out_last_q    <= out_last_d;
            pend_last_q   <= pend_last_d;
            pkt_stuffed_q <= pkt_stuffed_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;
    assign out_last    = out_last_q;
    assign pkt_stuffed = pkt_stuffed_q;

    // A pending stuff bit always follows a completed run.
    a_stuff_after_run : assert property (@(posedge clk) disable iff (rst)
        stuff_pending |-> (ones_cnt == CW'(RUN_LEN)));

endmodule

// File: tb/tb_bit_stuffer.sv
// Self-checking bench for bit_stuffer. A queue-based model expands every
// accepted input bit into the bits the stuffer owes downstream; outputs,
// handshakes and per-packet stuff counts are compared against it.
module tb_bit_stuffer;
    import usb_tx_pkg::*;

    localparam int unsigned RUN_LEN = 6;
    localparam int unsigned CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_bit, in_last, in_ready;
    logic             out_valid, out_bit, out_last, out_ready;
    logic [CNT_W-1:0] pkt_stuffed;

    always #5 clk = ~clk;

    bit_stuffer #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .pkt_stuffed (pkt_stuffed)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        bit b;
        bit last;
    } obit_t;

    obit_t       exp_q[$];
    int unsigned pkt_q[$];
    int          run_m    = 0;
    int unsigned stuffs_m = 0;

    int ready_mode = 0;  // 0: always ready, 1: random, 2: one 3-cycle stall on a stuff
    int stall_cnt  = 0;
    bit stall_done = 0;

    bit pkt_bits[$];

    // Monitor and model, sampled mid-cycle.
    initial begin
        obit_t o;
        obit_t e;
        bit    pv = 0, pr = 0, pb = 0, pl = 0, prst = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_ready_rst", in_ready, 0);
                exp_q.delete();
                pkt_q.delete();
                run_m    = 0;
                stuffs_m = 0;
            end else begin
                check("out_valid", out_valid, exp_q.size() != 0);
                check("in_ready", in_ready,
                      (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
                if (pv && !pr && !prst) begin
                    check("hold_bit", out_bit, pb);
                    check("hold_last", out_last, pl);
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    o = exp_q.pop_front();
                    check("out_bit", out_bit, o.b);
                    check("out_last", out_last, o.last);
                    if (o.last && pkt_q.size() != 0) begin
                        check("pkt_stuffed", pkt_stuffed, pkt_q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back('{b: in_bit, last: 1'b0});
                    run_m = in_bit ? run_m + 1 : 0;
                    if (run_m == RUN_LEN) begin
                        exp_q.push_back('{b: 1'b0, last: 1'b0});
                        run_m = 0;
                        stuffs_m++;
                    end
                    if (in_last) begin
                        e = exp_q.pop_back();
                        e.last = 1'b1;
                        exp_q.push_back(e);
                        pkt_q.push_back(stuffs_m > 255 ? 255 : stuffs_m);
                        stuffs_m = 0;
                        run_m    = 0;
                    end
                end
            end
            pv   = out_valid;
            pr   = out_ready;
            pb   = out_bit;
            pl   = out_last;
            prst = rst;
        end
    end

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < 75);
                default: begin
                    if (stall_cnt > 0) begin
                        out_ready = 1'b0;
                        stall_cnt--;
                    end else if (!stall_done && exp_q.size() > 1) begin
                        out_ready  = 1'b0;
                        stall_cnt  = 2;
                        stall_done = 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Drive pkt_bits upstream; called and returning at posedge+1.
    task automatic send_pkt(input bit with_last, input int gap_pct);
        bit took;
        int waited;
        for (int i = 0; i < pkt_bits.size(); i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_bit   = pkt_bits[i];
            in_last  = with_last && (i == pkt_bits.size() - 1);
            waited   = 0;
            do begin
                @(negedge clk);
                took = in_ready;
                @(posedge clk);
                #1;
                waited++;
            end while (!took && waited < 100);
            if (!took) check("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic load_ones(input int n);
        pkt_bits.delete();
        for (int i = 0; i < n; i++) pkt_bits.push_back(1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_pkt_stuffed", pkt_stuffed, 0);
        @(posedge clk);
        #1;

        // Eight 1s: one stuff after the sixth.
        load_ones(8);
        send_pkt(1, 0);
        drain();
        check("eight_ones", pkt_stuffed, 1);

        // Six 1s: the stuffed 0 carries the packet end.
        load_ones(6);
        send_pkt(1, 0);
        drain();
        check("six_ones", pkt_stuffed, 1);

        // 11111 0 111111 0: only the second run stuffs.
        pkt_bits = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
        send_pkt(1, 0);
        drain();
        check("split_runs", pkt_stuffed, 1);

        // Thirteen 1s: two stuffs.
        load_ones(13);
        send_pkt(1, 0);
        drain();
        check("thirteen_ones", pkt_stuffed, 2);

        // Downstream stall while a stuff bit is pending.
        ready_mode = 2;
        stall_done = 0;
        load_ones(8);
        send_pkt(1, 0);
        drain();
        check("stall_stuffed", pkt_stuffed, 1);
        check("stall_hit", stall_done, 1);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Reset mid-packet, then a short clean packet.
        load_ones(4);
        send_pkt(0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_bit", out_bit, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_stuffed", pkt_stuffed, 0);
        @(posedge clk);
        #1;
        load_ones(5);
        send_pkt(1, 0);
        drain();
        check("post_rst_pkt", pkt_stuffed, 0);

        // Random packets with upstream gaps and downstream backpressure.
        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            pkt_bits.delete();
            for (int i = 0; i < int'($urandom_range(1, 30)); i++) begin
                pkt_bits.push_back($urandom_range(0, 99) < 85);
            end
            send_pkt(1, 20);
        end
        drain();
        check("pkt_queue_empty", pkt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
